// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the UART transmit scheduler and its neighbours
// (uart_rx echo source, heartbeat source, uart_tx).
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          hb_req;
  logic [7:0]    hb_byte;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          busy;

  modport master (
    input  rx_dv, rx_byte, hb_req, hb_byte, tx_active, tx_done,
    output tx_dv, tx_byte, fifo_count, overflow, busy
  );

  modport slave (
    output rx_dv, rx_byte, hb_req, hb_byte, tx_active, tx_done,
    input  tx_dv, tx_byte, fifo_count, overflow, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between the echo FIFO and the heartbeat byte.
// Optional: define UART_TX_SCHED_CRLF_EN to follow each echoed CR with an LF.
//
// state | meaning
// SYNC  | after reset, wait for uart_tx to finish any frame in flight
// IDLE  | arbitrate between echo FIFO and pending heartbeat
// SEND  | tx_dv pulse for the granted byte
// WAIT  | hold tx_byte until tx_done
// GAP   | one cycle for uart_tx to settle back to idle
module uart_tx_scheduler #(
  parameter int DEPTH   = 16,
  parameter int HB_FAIR = 1
) (
  input logic                 hwclk,
  input logic                 rst,
  uart_tx_scheduler_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {SYNC, IDLE, SEND, WAIT, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    tx_byte_q;
  logic          ovf_q;
  logic          hb_pend;
  logic          rr_echo;
  logic          grant_echo, grant_hb;
  logic          push, pop, fifo_nempty;
`ifdef UART_TX_SCHED_CRLF_EN
  logic          cr_pend;
  logic          lf_ins;
`endif

  assign fifo_nempty = (count != '0);
  assign pop         = grant_echo;
  assign push        = bus.rx_dv && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge hwclk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_echo = 1'b0;
    grant_hb   = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
    lf_ins     = 1'b0;
`endif
    case (state)
      SYNC: if (!bus.tx_active) state_nxt = IDLE;
      IDLE: begin
        if (fifo_nempty && hb_pend) begin
          // Round-robin tie break; rr_echo names the side that wins the next tie.
          if ((HB_FAIR != 0) && rr_echo) grant_echo = 1'b1;
          else                           grant_hb   = 1'b1;
        end else if (fifo_nempty) begin
          grant_echo = 1'b1;
        end else if (hb_pend) begin
          grant_hb = 1'b1;
        end
        if (grant_echo || grant_hb) state_nxt = SEND;
      end
      SEND: state_nxt = WAIT;
      WAIT: if (bus.tx_done) state_nxt = GAP;
      GAP: begin
`ifdef UART_TX_SCHED_CRLF_EN
        if (cr_pend) begin
          lf_ins    = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (push) mem[wr_ptr] <= bus.rx_byte;
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      hb_pend   <= 1'b0;
      rr_echo   <= 1'b1;
      tx_byte_q <= 8'h00;
`ifdef UART_TX_SCHED_CRLF_EN
      cr_pend   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bus.rx_dv && !push) ovf_q <= 1'b1;
      // A request landing on the grant cycle re-arms the flag.
      hb_pend <= bus.hb_req || (hb_pend && !grant_hb);
      if (grant_echo) begin
        tx_byte_q <= mem[rd_ptr];
        rr_echo   <= 1'b0;
      end
      if (grant_hb) begin
        tx_byte_q <= bus.hb_byte;
        rr_echo   <= 1'b1;
      end
`ifdef UART_TX_SCHED_CRLF_EN
      if (grant_echo) cr_pend <= (mem[rd_ptr] == 8'h0D);
      if (grant_hb)   cr_pend <= 1'b0;
      if (lf_ins) begin
        tx_byte_q <= 8'h0A;
        cr_pend   <= 1'b0;
      end
`endif
    end
  end

  assign bus.tx_dv      = (state == SEND) && !rst;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small uart_tx frame model.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 16;
  localparam int FRAME = 10;

  logic hwclk = 1'b0;
  logic rst   = 1'b1;
  always #5 hwclk = ~hwclk;

  uart_tx_scheduler_if #(.DEPTH(DEPTH)) ifc ();

  uart_tx_scheduler #(.DEPTH(DEPTH), .HB_FAIR(1)) dut (
    .hwclk (hwclk),
    .rst   (rst),
    .bus   (ifc.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic       man_active  = 1'b1;
  logic       mdl_active  = 1'b0;
  logic       mdl_done    = 1'b0;
  logic       stall       = 1'b0;
  logic       hold_chk_en = 1'b1;
  int         frm         = 0;
  logic [7:0] held        = 8'h00;
  logic [7:0] sent_q [$];

  assign ifc.tx_active = man_active | mdl_active;
  assign ifc.tx_done   = mdl_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in: accepts a DV, stays active FRAME cycles (frozen while stall), pulses done
  always @(negedge hwclk) begin
    mdl_done = 1'b0;
    if (ifc.tx_dv) begin
      chk("dv_overlap", 32'(frm), 32'd0);
      sent_q.push_back(ifc.tx_byte);
      held       = ifc.tx_byte;
      frm        = FRAME;
      mdl_active = 1'b1;
    end else if (frm > 0 && !stall) begin
      frm--;
      if (frm == 0) begin
        mdl_active = 1'b0;
        mdl_done   = 1'b1;
        if (hold_chk_en) chk("tx_byte_hold", 32'(ifc.tx_byte), 32'(held));
      end
    end
  end

  task automatic push(input logic [7:0] b);
    ifc.rx_dv   = 1'b1;
    ifc.rx_byte = b;
    @(negedge hwclk);
    ifc.rx_dv   = 1'b0;
  endtask

  task automatic hb_pulse();
    ifc.hb_req = 1'b1;
    @(negedge hwclk);
    ifc.hb_req = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (sent_q.size() < n && k < budget) begin
      @(negedge hwclk);
      k++;
    end
    if (sent_q.size() < n) chk("wait_sent_timeout", 32'(sent_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((ifc.busy || frm != 0 || ifc.fifo_count != 0) && k < budget) begin
      @(negedge hwclk);
      k++;
    end
    if (k >= budget)
      chk("wait_idle_timeout", {29'd0, ifc.busy, frm != 0, ifc.fifo_count != 0}, 32'd0);
  endtask

  task automatic wait_busy_low(input int budget);
    int k = 0;
    while (ifc.busy && k < budget) begin
      @(negedge hwclk);
      k++;
    end
    if (ifc.busy) chk("wait_busy_low_timeout", 32'(ifc.busy), 32'd0);
  endtask

  task automatic cmp_seq(input string tag, input logic [7:0] exp_q [$]);
    chk({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent_q.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       dv_seen;
    logic       busy_all;
    logic [7:0] exp_q [$];

    ifc.rx_dv   = 1'b0;
    ifc.rx_byte = 8'h00;
    ifc.hb_req  = 1'b0;
    ifc.hb_byte = 8'h2A;

    // reset values, then SYNC held off by an active frame
    repeat (3) @(negedge hwclk);
    chk("rst_tx_dv",   32'(ifc.tx_dv),      32'd0);
    chk("rst_tx_byte", 32'(ifc.tx_byte),    32'h00);
    chk("rst_count",   32'(ifc.fifo_count), 32'd0);
    chk("rst_ovf",     32'(ifc.overflow),   32'd0);
    chk("rst_busy",    32'(ifc.busy),       32'd1);
    rst = 1'b0;
    push(8'h55);
    dv_seen  = 1'b0;
    busy_all = 1'b1;
    repeat (48) begin
      @(negedge hwclk);
      dv_seen  = dv_seen | ifc.tx_dv;
      busy_all = busy_all & ifc.busy;
    end
    chk("sync_no_dv",  32'(dv_seen),        32'd0);
    chk("sync_busy",   32'(busy_all),       32'd1);
    chk("sync_count",  32'(ifc.fifo_count), 32'd1);
    man_active = 1'b0;
    @(negedge hwclk);
    chk("sync_exit_dv",   32'(ifc.tx_dv), 32'd0);
    chk("sync_exit_busy", 32'(ifc.busy),  32'd0);
    @(negedge hwclk);
    chk("sync_first_dv",   32'(ifc.tx_dv),   32'd1);
    chk("sync_first_byte", 32'(ifc.tx_byte), 32'h55);
    wait_sent(1, 200);
    wait_idle(200);

    // single echo byte latency
    sent_q.delete();
    ifc.rx_dv = 1'b1; ifc.rx_byte = 8'h41;
    @(negedge hwclk);
    ifc.rx_dv = 1'b0;
    chk("echo_n1_count", 32'(ifc.fifo_count), 32'd1);
    chk("echo_n1_dv",    32'(ifc.tx_dv),      32'd0);
    @(negedge hwclk);
    chk("echo_n2_dv",    32'(ifc.tx_dv),      32'd1);
    chk("echo_n2_byte",  32'(ifc.tx_byte),    32'h41);
    chk("echo_n2_count", 32'(ifc.fifo_count), 32'd0);
    wait_sent(1, 200);
    wait_idle(200);
    exp_q = '{8'h41};
    cmp_seq("echo_single", exp_q);

    // fill while stalled, push+pop at full, then overflow
    sent_q.delete();
    stall = 1'b1;
    push(8'hEE);
    wait_sent(1, 50);
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("full_count", 32'(ifc.fifo_count), 32'd16);
    chk("full_ovf",   32'(ifc.overflow),   32'd0);
    stall = 1'b0;
    wait_busy_low(200);
    stall = 1'b1;
    ifc.rx_dv = 1'b1; ifc.rx_byte = 8'h10;
    @(negedge hwclk);
    ifc.rx_dv = 1'b0;
    chk("pushpop_count", 32'(ifc.fifo_count), 32'd16);
    chk("pushpop_ovf",   32'(ifc.overflow),   32'd0);
    push(8'h11);
    chk("drop_count", 32'(ifc.fifo_count), 32'd16);
    chk("drop_ovf",   32'(ifc.overflow),   32'd1);
    stall = 1'b0;
    wait_sent(18, 2000);
    wait_idle(200);
    repeat (30) @(negedge hwclk);
    chk("ovf_sticky", 32'(ifc.overflow), 32'd1);
    exp_q = '{8'hEE};
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
    cmp_seq("burst", exp_q);

    // reset mid-frame: DV drops at once, FIFO discarded, frame allowed to finish
    sent_q.delete();
    push(8'h99);
    push(8'h98);
    begin
      int k = 0;
      while (!ifc.tx_dv && k < 20) begin
        @(negedge hwclk);
        k++;
      end
    end
    hold_chk_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_dv_drop", 32'(ifc.tx_dv), 32'd0);
    @(negedge hwclk);
    @(negedge hwclk);
    rst = 1'b0;
    chk("midrst_count", 32'(ifc.fifo_count), 32'd0);
    chk("midrst_ovf",   32'(ifc.overflow),   32'd0);
    chk("midrst_busy",  32'(ifc.busy),       32'd1);
    wait_idle(200);
    repeat (30) @(negedge hwclk);
    hold_chk_en = 1'b1;
    exp_q = '{8'h99};
    cmp_seq("midrst", exp_q);

    // round-robin with coalesced heartbeat requests
    sent_q.delete();
    stall = 1'b1;
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    hb_pulse();
    hb_pulse();
    chk("rr_count", 32'(ifc.fifo_count), 32'd2);
    stall = 1'b0;
    wait_sent(2, 200);
    hb_pulse();
    wait_sent(5, 500);
    wait_idle(200);
    repeat (40) @(negedge hwclk);
    exp_q = '{8'hA0, 8'h2A, 8'hA1, 8'h2A, 8'hA2};
    cmp_seq("rr", exp_q);

    // heartbeat request on the cycle it is granted is kept
    sent_q.delete();
    stall = 1'b1;
    push(8'hEE);
    wait_sent(1, 50);
    hb_pulse();
    stall = 1'b0;
    wait_busy_low(200);
    hb_pulse();
    wait_sent(3, 500);
    wait_idle(200);
    repeat (40) @(negedge hwclk);
    exp_q = '{8'hEE, 8'h2A, 8'h2A};
    cmp_seq("hb_regrant", exp_q);

    // CR handling
    sent_q.delete();
    push(8'h0D);
    push(8'h42);
`ifdef UART_TX_SCHED_CRLF_EN
    exp_q = '{8'h0D, 8'h0A, 8'h42};
`else
    exp_q = '{8'h0D, 8'h42};
`endif
    wait_sent(exp_q.size(), 500);
    wait_idle(200);
    repeat (40) @(negedge hwclk);
    cmp_seq("crlf", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Owns the transmit side of the UART.
- Shares one uart_tx instance between two requesters:
  - the echo path, fed by uart_rx output and buffered in an internal FIFO;
  - a heartbeat path, which sends a single status byte per request pulse.
- Replaces ad-hoc edge-triggered DV logic with one synchronous controller in the hwclk domain.
- Drives the uart_tx DV/byte inputs and sequences on its Active/Done outputs.

Parameters:
- DEPTH, 16, echo FIFO depth in bytes; power of two, 2..256.
- HB_FAIR, 1, 1 = round-robin between echo and heartbeat; 0 = heartbeat has strict priority.

Ports:
- hwclk  in  1  system clock, 12 MHz
- rst  in  1  synchronous active-high reset
- rx_dv  in  1  one-cycle pulse from uart_rx: rx_byte valid
- rx_byte  in  8  received byte
- hb_req  in  1  one-cycle heartbeat request pulse, e.g. from the 1 Hz divider
- hb_byte  in  8  heartbeat byte; sampled when the heartbeat is granted
- tx_dv  out  1  to uart_tx i_Tx_DV; one-cycle pulse
- tx_byte  out  8  to uart_tx i_Tx_Byte; held stable from the DV cycle until tx_done
- tx_active  in  1  from uart_tx o_Tx_Active
- tx_done  in  1  from uart_tx o_Tx_Done; one-cycle pulse
- fifo_count  out  $clog2(DEPTH)+1  current echo FIFO occupancy
- overflow  out  1  sticky: an rx byte was dropped because the FIFO was full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: tx_dv=0, tx_byte=8'h00, fifo_count=0, overflow=0, busy=1 (state SYNC), hb pending flag=0, rr pointer=echo. FIFO pointers are cleared.
- Echo FIFO:
  - Push on rx_dv if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set. overflow clears only on rst.
  - Pointers wrap modulo DEPTH.
- Heartbeat:
  - hb_req sets hb_pend.
  - Repeated hb_req while pending coalesce into one send.
  - hb_req in the same cycle hb_pend is cleared by a grant re-sets hb_pend, so the request is not lost.
- FSM states:
  - SYNC: wait until tx_active=0, then go to IDLE. This covers a reset landing mid-frame: no DV is issued while uart_tx is still shifting.
  - IDLE: arbitrate when the FIFO is non-empty or hb_pend=1.
    - Grant echo: tx_byte<=FIFO head, pop.
    - Grant heartbeat: tx_byte<=hb_byte, clear hb_pend.
    - Then go to SEND.
  - SEND: tx_dv=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold tx_byte; on tx_done go to GAP.
  - GAP: one idle cycle so uart_tx can return to idle, then go to IDLE.
- Arbitration:
  - HB_FAIR=1: when both are ready, grant the side opposite the last grant; the pointer updates on every grant.
  - HB_FAIR=0: heartbeat always wins.
- Latency:
  - rx_dv in cycle N with the FSM in IDLE and the FIFO empty: pop/grant in N+1, tx_dv=1 in N+2.
  - Back-to-back bytes are spaced by frame time + 3 cycles (GAP, IDLE, SEND).
- tx_done outside WAIT is ignored.
- tx_active is used only in SYNC. The FSM does not time out; uart_tx always completes a frame.
- rst mid-operation:
  - FIFO contents are discarded and tx_dv drops the same cycle.
  - An in-flight frame completes on the line before the next DV.

Optional Feature:
- Macro: UART_TX_SCHED_CRLF_EN.
- Defined:
  - After an echo byte 8'h0D completes (tx_done in WAIT), the FSM goes GAP→SEND with tx_byte=8'h0A. No pop and no arbitration for that byte.
  - The inserted LF is not counted in fifo_count.
  - Heartbeat bytes are never expanded.
- Undefined: all bytes are sent verbatim; the CR-tracking flag and the extra FSM path are absent.

Test Plan:
1. Reset → release with tx_active=1 for 50 cycles → tx_dv stays 0 until 2 cycles after tx_active falls, busy=1 in SYNC; no spurious DV.
2. Single rx_dv with 8'h41, FIFO empty → tx_dv pulse 2 cycles later with tx_byte=8'h41, held until tx_done; fifo_count goes 1→0.
3. Burst of DEPTH+2 rx_dv bytes 8'h00..8'h11 while uart_tx is stalled in WAIT (no tx_done) → fifo_count=16, overflow=1; bytes sent in order 8'h00..8'h0F; 8'h10 and 8'h11 never appear.
4. HB_FAIR=1, FIFO holding 3 bytes, hb_req with hb_byte=8'h2A during the first send → order: echo0, 8'h2A, echo1, echo2. A second hb_req during the 8'h2A send yields exactly one more 8'h2A.
5. Simultaneous rx_dv and pop at FIFO full → push accepted, fifo_count stays 16, overflow stays 0.
6. With UART_TX_SCHED_CRLF_EN defined, echo of 8'h0D, 8'h42 → line carries 8'h0D, 8'h0A, 8'h42. Without the macro → 8'h0D, 8'h42.
